// File: rtl/sync_multi_edge_det.sv
// Multi-channel level synchronizer with an optional per-channel stability filter
// and registered rise/fall/edge pulses derived from the filtered level.
`timescale 1ns/1ps

module sync_multi_edge_det #(
   parameter int unsigned CH       = 4,
   parameter int unsigned STAGES   = 2,
   parameter int unsigned FILT_CNT = 0,
   parameter logic        RST_VAL  = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] async_in,
   output logic [CH-1:0] level_out,
   output logic [CH-1:0] rise_pulse,
   output logic [CH-1:0] fall_pulse,
   output logic [CH-1:0] edge_pulse
);

   if (STAGES < 2) begin : g_stages_chk
      $error("sync_multi_edge_det: STAGES must be >= 2");
   end

   logic [CH-1:0] synced;
   logic [CH-1:0] level_q;
   logic [CH-1:0] level_d;
   logic [CH-1:0] rise_q;
   logic [CH-1:0] fall_q;

   // Plain flop chain per channel; nothing may sit between these stages.
   for (genvar i = 0; i < CH; i++) begin : g_chain
      (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            chain_q <= {STAGES{RST_VAL}};
         end else begin
            chain_q <= {chain_q[STAGES-2:0], async_in[i]};
         end
      end

      assign synced[i] = chain_q[STAGES-1];
   end

   if (FILT_CNT <= 1) begin : g_no_filt
      assign level_d = synced;
   end else begin : g_filt
      localparam int unsigned CntW = $clog2(FILT_CNT);
      localparam logic [CntW-1:0] CntMax = CntW'(FILT_CNT - 1);

      logic [CntW-1:0] cnt_q [CH];
      logic [CntW-1:0] cnt_d [CH];

      // Counter restarts on any return to the current level: no partial credit.
      always_comb begin
         level_d = level_q;
         for (int i = 0; i < CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (synced[i] == level_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
               level_d[i] = synced[i];
               cnt_d[i]   = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CntW'(1);
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < CH; i++) begin
               cnt_q[i] <= '0;
            end
         end else begin
            for (int i = 0; i < CH; i++) begin
               cnt_q[i] <= cnt_d[i];
            end
         end
      end
   end

   // Pulses register alongside the level so both change on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q <= {CH{RST_VAL}};
         rise_q  <= '0;
         fall_q  <= '0;
      end else begin
         level_q <= level_d;
         rise_q  <= ~level_q & level_d;
         fall_q  <= level_q & ~level_d;
      end
   end

   assign level_out  = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign edge_pulse = rise_q | fall_q;

endmodule

// File: tb/tb_sync_multi_edge_det.sv
// Bench for sync_multi_edge_det: four parameterisations checked against a
// sliding-window model of the synchronizer and filter.
`timescale 1ns/1ps

module tb_sync_multi_edge_det;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] ain [4];
   logic [3:0] lv  [4];
   logic [3:0] rp  [4];
   logic [3:0] fp  [4];
   logic [3:0] ep  [4];

   int total = 0;
   int bad   = 0;

   int stg [4] = '{2, 3, 2, 2};
   int fc  [4] = '{0, 4, 2, 4};
   bit rv  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   // hist[k][c][j]: input value sampled j+1 edges ago (index 0 = most recent edge)
   bit       hist [4][4][16];
   bit [3:0] m_lv [4];
   bit [3:0] m_rp [4];
   bit [3:0] m_fp [4];

   always #5 clk = ~clk;

   sync_multi_edge_det #(.CH(4), .STAGES(2), .FILT_CNT(0), .RST_VAL(1'b0)) u0 (
      .clk(clk), .rst(rst), .async_in(ain[0]), .level_out(lv[0]),
      .rise_pulse(rp[0]), .fall_pulse(fp[0]), .edge_pulse(ep[0]));
   sync_multi_edge_det #(.CH(4), .STAGES(3), .FILT_CNT(4), .RST_VAL(1'b0)) u1 (
      .clk(clk), .rst(rst), .async_in(ain[1]), .level_out(lv[1]),
      .rise_pulse(rp[1]), .fall_pulse(fp[1]), .edge_pulse(ep[1]));
   sync_multi_edge_det #(.CH(4), .STAGES(2), .FILT_CNT(2), .RST_VAL(1'b0)) u2 (
      .clk(clk), .rst(rst), .async_in(ain[2]), .level_out(lv[2]),
      .rise_pulse(rp[2]), .fall_pulse(fp[2]), .edge_pulse(ep[2]));
   sync_multi_edge_det #(.CH(4), .STAGES(2), .FILT_CNT(4), .RST_VAL(1'b1)) u3 (
      .clk(clk), .rst(rst), .async_in(ain[3]), .level_out(lv[3]),
      .rise_pulse(rp[3]), .fall_pulse(fp[3]), .edge_pulse(ep[3]));

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_lv[k] = {4{rv[k]}};
         m_rp[k] = '0;
         m_fp[k] = '0;
         for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 16; j++) hist[k][c][j] = rv[k];
         end
      end
   endtask

   // Level flips once the last max(1,FILT_CNT) synced values all differ from it.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
               int w;
               bit flip;
               bit nl;
               w    = (fc[k] > 1) ? fc[k] : 1;
               flip = 1'b1;
               for (int j = stg[k] - 1; j <= stg[k] + w - 2; j++) begin
                  if (hist[k][c][j] == m_lv[k][c]) flip = 1'b0;
               end
               nl         = flip ? ~m_lv[k][c] : m_lv[k][c];
               m_rp[k][c] = ~m_lv[k][c] & nl;
               m_fp[k][c] = m_lv[k][c] & ~nl;
               m_lv[k][c] = nl;
               for (int j = 15; j > 0; j--) hist[k][c][j] = hist[k][c][j-1];
               hist[k][c][0] = ain[k][c];
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) ain[k] = {4{rv[k]}};
      #1;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         total++;
         if (lv[k] !== {4{rv[k]}} || ep[k] !== 4'h0 || rp[k] !== 4'h0 || fp[k] !== 4'h0) begin
            bad++;
            $display("FAIL reset inst%0d: level=%h pulses r%h f%h e%h, want level=%h pulses 0",
                     k, lv[k], rp[k], fp[k], ep[k], {4{rv[k]}});
         end
      end
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic test_latency();
      ain[0][0] = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         tick();
         total++;
         if (lv[0][0] !== (n >= 3) || rp[0][0] !== (n == 3) || fp[0][0] !== 1'b0) begin
            bad++;
            $display("FAIL latency edge%0d: level=%b rise=%b fall=%b, want level=%b rise=%b fall=0",
                     n, lv[0][0], rp[0][0], fp[0][0], n >= 3, n == 3);
         end
      end
   endtask

   task automatic test_filter_fall();
      ain[1] = 4'b0010;
      repeat (10) tick();
      total++;
      if (lv[1] !== 4'b0010) begin
         bad++;
         $display("FAIL filt_settle: level=%h want 2", lv[1]);
      end
      ain[1] = 4'b0000;
      for (int n = 1; n <= 10; n++) begin
         logic [3:0] want_l;
         logic [3:0] want_f;
         tick();
         want_l = (n >= 7) ? 4'b0000 : 4'b0010;
         want_f = (n == 7) ? 4'b0010 : 4'b0000;
         total++;
         if (lv[1] !== want_l || fp[1] !== want_f || rp[1] !== 4'h0) begin
            bad++;
            $display("FAIL filt_fall edge%0d: level=%h fall=%h rise=%h, want level=%h fall=%h rise=0",
                     n, lv[1], fp[1], rp[1], want_l, want_f);
         end
      end
   endtask

   task automatic test_glitch();
      int rises;
      int falls;
      for (int len = 3; len <= 4; len++) begin
         rises = 0;
         falls = 0;
         ain[1][2] = 1'b1;
         for (int n = 0; n < 20; n++) begin
            if (n == len) ain[1][2] = 1'b0;
            tick();
            rises += int'(rp[1][2]);
            falls += int'(fp[1][2]);
            total++;
            if ({lv[1], rp[1], fp[1]} !== {m_lv[1], m_rp[1], m_fp[1]}) begin
               bad++;
               $display("FAIL glitch_model len%0d: got l%h r%h f%h want l%h r%h f%h", len,
                        lv[1], rp[1], fp[1], m_lv[1], m_rp[1], m_fp[1]);
            end
         end
         total++;
         if (rises !== len - 3 || falls !== len - 3) begin
            bad++;
            $display("FAIL glitch_count len%0d: rises=%0d falls=%0d want %0d each",
                     len, rises, falls, len - 3);
         end
      end
   endtask

   task automatic test_alternate();
      int edges;
      edges = 0;
      for (int n = 0; n < 20; n++) begin
         ain[2][3] = ~ain[2][3];
         tick();
         edges += int'(ep[2][3]);
         total++;
         if (lv[2][3] !== 1'b0) begin
            bad++;
            $display("FAIL alternate_level cyc%0d: level=%b want 0", n, lv[2][3]);
         end
      end
      ain[2][3] = 1'b0;
      total++;
      if (edges !== 0) begin
         bad++;
         $display("FAIL alternate_pulses: edges=%0d want 0", edges);
      end
      repeat (4) tick();
   endtask

   task automatic test_reset_mid();
      ain[1] = 4'hF;
      repeat (5) tick();
      rst = 1'b1;
      #1;
      model_reset();
      total++;
      if (lv[1] !== 4'h0 || ep[1] !== 4'h0) begin
         bad++;
         $display("FAIL reset_mid_assert: level=%h edge=%h want 0 0", lv[1], ep[1]);
      end
      repeat (2) tick();
      rst = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         logic [3:0] want_r;
         tick();
         want_r = (n == 7) ? 4'hF : 4'h0;
         total++;
         if (rp[1] !== want_r || fp[1] !== 4'h0) begin
            bad++;
            $display("FAIL reset_mid_release edge%0d: rise=%h fall=%h want rise=%h fall=0",
                     n, rp[1], fp[1], want_r);
         end
      end
   endtask

   task automatic test_rst_val_one();
      ain[3] = 4'hF;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         tick();
         total++;
         if (lv[3] !== 4'hF || ep[3] !== 4'h0) begin
            bad++;
            $display("FAIL rst_val_one edge%0d: level=%h edge=%h want F 0", n, lv[3], ep[3]);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         for (int k = 0; k < 4; k++) begin
            logic [3:0] m;
            m = 4'($urandom & $urandom);
            ain[k] = ain[k] ^ m;
         end
         if (n % 150 == 149) rst = 1'b1;
         if (n % 150 == 2) rst = 1'b0;
         if (rst) begin
            #1;
            model_reset();
         end
         tick();
         for (int k = 0; k < 4; k++) begin
            total++;
            if ({lv[k], rp[k], fp[k], ep[k]} !== {m_lv[k], m_rp[k], m_fp[k], m_rp[k] | m_fp[k]}) begin
               bad++;
               $display("FAIL random inst%0d cyc%0d: got l%h r%h f%h e%h want l%h r%h f%h e%h",
                        k, n, lv[k], rp[k], fp[k], ep[k],
                        m_lv[k], m_rp[k], m_fp[k], m_rp[k] | m_fp[k]);
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_filter_fall();
      test_glitch();
      test_alternate();
      test_reset_mid();
      test_rst_val_one();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
